// File: rtl/writeback_router_pkg.sv
// Shared constants for the writeback router: lane width, op codes (common
// with the forward operand chooser) and the capture/commit FSM states.
package writeback_router_pkg;

  localparam int unsigned WIDTH = 8;

  localparam logic [1:0] OP_ZERO = 2'b00;
  localparam logic [1:0] OP_DT   = 2'b01;
  localparam logic [1:0] OP_YZAB = 2'b10;
  localparam logic [1:0] OP_XZAB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_CAPT   = 2'b01,
    ST_COMMIT = 2'b10
  } state_e;

endpackage

// File: rtl/writeback_permute.sv
// Combinational inverse map from result lanes a/b/c back onto x/y/z.
module writeback_permute
  import writeback_router_pkg::*;
#(
  parameter int unsigned WIDTH = writeback_router_pkg::WIDTH
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] nx_o,
  output logic [WIDTH-1:0] ny_o,
  output logic [WIDTH-1:0] nz_o
);

  always_comb begin
    nx_o = '0;
    ny_o = '0;
    nz_o = '0;
    case (op_i)
      OP_DT: begin
        nx_o = a_i;
        ny_o = b_i;
        nz_o = c_i;
      end
      OP_YZAB: begin
        ny_o = a_i;
        nz_o = b_i;
        nx_o = c_i;
      end
      OP_XZAB: begin
        nx_o = a_i;
        nz_o = b_i;
        ny_o = c_i;
      end
      default: begin
        nx_o = '0;
        ny_o = '0;
        nz_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/writeback_router.sv
// Writeback router: valid/ready capture of a/b/c results, inverse permute,
// then commit onto architectural x/y/z registers (IDLE -> CAPT -> COMMIT).
module writeback_router
  import writeback_router_pkg::*;
#(
  parameter int unsigned WIDTH = writeback_router_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             done,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [1:0]       hop_q, hop_d;
  logic [WIDTH-1:0] ha_q, ha_d, hb_q, hb_d, hc_q, hc_d;
  logic [WIDTH-1:0] nx_q, nx_d, ny_q, ny_d, nz_q, nz_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] px, py, pz;

  writeback_permute #(.WIDTH(WIDTH)) u_permute (
    .op_i (hop_q),
    .a_i  (ha_q),
    .b_i  (hb_q),
    .c_i  (hc_q),
    .nx_o (px),
    .ny_o (py),
    .nz_o (pz)
  );

  assign in_ready = (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    hop_d   = hop_q;
    ha_d    = ha_q;
    hb_d    = hb_q;
    hc_d    = hc_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    nz_d    = nz_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          hop_d   = op;
          ha_d    = a;
          hb_d    = b;
          hc_d    = c;
          state_d = ST_CAPT;
        end
      end
      ST_CAPT: begin
        nx_d    = px;
        ny_d    = py;
        nz_d    = pz;
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        x_d     = nx_q;
        y_d     = ny_q;
        z_d     = nz_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered so busy tracks state_q exactly without a combinational path.
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hop_q   <= '0;
      ha_q    <= '0;
      hb_q    <= '0;
      hc_q    <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      nz_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hop_q   <= hop_d;
      ha_q    <= ha_d;
      hb_q    <= hb_d;
      hc_q    <= hc_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      nz_q    <= nz_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign z    = z_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_writeback_router.sv
// Directed and random checks of the writeback router capture/commit path.
module tb_writeback_router;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [7:0] a, b, c;
  logic [7:0] x, y, z;
  logic       done;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  writeback_router #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .c        (c),
    .x        (x),
    .y        (y),
    .z        (z),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] ref_map(input logic [1:0] o, input logic [7:0] ra,
                                          input logic [7:0] rb, input logic [7:0] rc);
    // returns {x,y,z}
    if (o == 2'b01) return {ra, rb, rc};
    if (o == 2'b10) return {rc, ra, rb};
    if (o == 2'b11) return {ra, rc, rb};
    return 24'h0;
  endfunction

  // Present one transfer, wait for acceptance, then check the 2-edge commit.
  task automatic send(input string tag, input logic [1:0] o, input logic [7:0] ra,
                      input logic [7:0] rb, input logic [7:0] rc);
    int k;
    logic [23:0] e;
    e = ref_map(o, ra, rb, rc);
    op = o; a = ra; b = rb; c = rc;
    in_valid = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 10) begin
      tick();
      k++;
    end
    chk({tag, "_ready_wait"}, 32'(k < 10), 32'd1);
    tick();
    in_valid = 1'b0;
    op = ~o; a = ~ra; b = ~rb; c = ~rc;
    chk({tag, "_busy_capt"}, 32'(busy), 32'd1);
    chk({tag, "_rdy_capt"}, 32'(in_ready), 32'd0);
    chk({tag, "_done_capt"}, 32'(done), 32'd0);
    tick();
    chk({tag, "_busy_commit"}, 32'(busy), 32'd1);
    chk({tag, "_rdy_commit"}, 32'(in_ready), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    chk({tag, "_xyz"}, 32'({x, y, z}), 32'(e));
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; c = '0;
    #12;
    chk("rst_x", 32'(x), 32'h0);
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_z", 32'(z), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // DT
    d0 = done_cnt;
    send("dt", 2'b01, 8'h11, 8'h22, 8'h33);
    chk("dt_x", 32'(x), 32'h11);
    chk("dt_y", 32'(y), 32'h22);
    chk("dt_z", 32'(z), 32'h33);
    tick();
    chk("dt_done_low", 32'(done), 32'h0);
    chk("dt_hold", 32'({x, y, z}), 32'h112233);
    chk("dt_done_once", 32'(done_cnt - d0), 32'd1);

    // ZERO after DT
    send("zero", 2'b00, 8'h55, 8'h66, 8'h77);
    chk("zero_xyz", 32'({x, y, z}), 32'h0);

    // YZAB and XZAB
    send("yzab", 2'b10, 8'hA1, 8'hB2, 8'hC3);
    chk("yzab_xyz", 32'({x, y, z}), 32'hC3A1B2);
    send("xzab", 2'b11, 8'hA1, 8'hB2, 8'hC3);
    chk("xzab_xyz", 32'({x, y, z}), 32'hA1C3B2);

    // Reset during COMMIT of DT 11/22/33
    tick();
    op = 2'b01; a = 8'h11; b = 8'h22; c = 8'h33; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_in_commit", 32'(busy), 32'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_xyz", 32'({x, y, z}), 32'h0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mid_no_commit", 32'({x, y, z}), 32'h0);
    chk("mid_no_done", 32'(done_cnt - d0), 32'd0);

    // Back-to-back with data changing every cycle
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i >= 3 && i % 3 == 0) begin
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_xyz", 32'({x, y, z}), 32'({8'(i - 3), 8'(i - 3 + 8'h40), 8'(i - 3 + 8'h80)}));
      end else if (i >= 3) begin
        chk("b2b_done_low", 32'(done), 32'd0);
      end
      chk("b2b_ready", 32'(in_ready), 32'(i % 3 == 0));
      op = 2'b01; a = 8'(i); b = 8'(i + 8'h40); c = 8'(i + 8'h80);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("b2b_last", 32'({x, y, z}), 32'h0949_89);
    tick();

    // Random transfers with random idle gaps
    d0 = done_cnt;
    for (int n = 0; n < 1000; n++) begin
      logic [1:0] ro;
      logic [7:0] ra, rb, rc;
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
      send("rnd", ro, ra, rb, rc);
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();
    chk("rnd_done_count", 32'(done_cnt - d0), 32'd1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
